// File: rtl/exec_pkg.sv
// Shared encodings for the execute-stage datapath: ALU control codes, ALUOp values
// and R-type funct fields.
package exec_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  // ALUOp 11 is not issued by the control FSM; it decodes the same as fetch/address ADD.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } alu_op_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  function automatic alu_ctrl_e funct_to_ctrl(input logic [5:0] funct);
    alu_ctrl_e ctrl;
    case (funct)
      FUNCT_ADD: ctrl = ALU_ADD;
      FUNCT_SUB: ctrl = ALU_SUB;
      FUNCT_AND: ctrl = ALU_AND;
      FUNCT_OR:  ctrl = ALU_OR;
      FUNCT_SLT: ctrl = ALU_SLT;
      default:   ctrl = ALU_ADD;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU-control decoder: maps the control FSM's ALUOp and the instruction funct
// field onto the 3-bit ALU operation code.
module alu_decoder
  import exec_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_ADD:   alu_ctrl = ALU_ADD;
      ALUOP_SUB:   alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: alu_ctrl = funct_to_ctrl(funct);
      default:     alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/exec_regfile_alu.sv
// Execute-stage core of the multicycle MIPS: 32x32 register file, ALU-control decode and ALU.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data onto matching read ports.
module exec_regfile_alu
  import exec_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] read_reg_a,
  input  logic [ADDR_W-1:0] read_reg_b,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] reg_a,
  output logic [DATA_W-1:0] reg_b,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_ctrl,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic              write_en;
  logic              slt_bit;

  assign write_en = reg_write && (write_reg != '0);

  // Entry 0 is never written, so the hardwired-zero register stays 0 even before the read gating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (write_en) begin
      regs[write_reg] <= write_data;
    end
  end

  always_comb begin
    reg_a = (read_reg_a == '0) ? '0 : regs[read_reg_a];
    reg_b = (read_reg_b == '0) ? '0 : regs[read_reg_b];
`ifdef REGFILE_BYPASS_EN
    // Reset wins over forwarding so a write strobed during reset never leaks out.
    if (rst_n && write_en && (write_reg == read_reg_a)) begin
      reg_a = write_data;
    end
    if (rst_n && write_en && (write_reg == read_reg_b)) begin
      reg_b = write_data;
    end
`endif
  end

  alu_decoder u_alu_decoder (
    .alu_op   (alu_op),
    .funct    (funct),
    .alu_ctrl (alu_ctrl)
  );

  assign slt_bit = ($signed(alu_a) < $signed(alu_b));

  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_SUB: alu_result = alu_a - alu_b;
      ALU_SLT: alu_result = {{(DATA_W-1){1'b0}}, slt_bit};
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

endmodule

// File: tb/tb_exec_regfile_alu.sv
// Self-checking bench for exec_regfile_alu: directed register/ALU cases plus randomized
// traffic against a behavioural model (register array + named-operation ALU).
module tb_exec_regfile_alu;

  logic        clk;
  logic        rst_n;
  logic        reg_write;
  logic [4:0]  read_reg_a;
  logic [4:0]  read_reg_b;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] reg_a;
  logic [31:0] reg_b;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        zero;

  int tests_run;
  int tests_failed;

  logic [31:0] model_regs [32];

  exec_regfile_alu #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .reg_write  (reg_write),
    .read_reg_a (read_reg_a),
    .read_reg_b (read_reg_b),
    .write_reg  (write_reg),
    .write_data (write_data),
    .reg_a      (reg_a),
    .reg_b      (reg_b),
    .alu_op     (alu_op),
    .funct      (funct),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .zero       (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: name the operation from the ALUOp/funct rules, then evaluate it.
  function automatic string ref_op_name(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b01) return "sub";
    if (op != 2'b10) return "add";
    if (f == 6'h20) return "add";
    if (f == 6'h22) return "sub";
    if (f == 6'h24) return "and";
    if (f == 6'h25) return "or";
    if (f == 6'h2A) return "slt";
    return "add";
  endfunction

  function automatic logic [2:0] ref_ctrl(input string name);
    if (name == "and") return 3'd0;
    if (name == "or")  return 3'd1;
    if (name == "sub") return 3'd6;
    if (name == "slt") return 3'd7;
    return 3'd2;
  endfunction

  function automatic logic [31:0] ref_result(input string name, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (name == "and") return a & b;
    if (name == "or")  return a | b;
    if (name == "sub") return a - b;
    if (name == "slt") return (sa < sb) ? 32'd1 : 32'd0;
    return a + b;
  endfunction

  task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    write_reg  = addr;
    write_data = data;
    reg_write  = 1'b1;
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    if (rst_n && addr != 5'd0) model_regs[addr] = data;
  endtask

  task automatic check_reads(input logic [4:0] ra, input logic [4:0] rb, input string tag);
    read_reg_a = ra;
    read_reg_b = rb;
    #1;
    tests_run++;
    if (reg_a !== model_regs[ra]) begin
      tests_failed++;
      $display("[TB] FAIL %s reg_a[%0d]: got %h expected %h", tag, ra, reg_a, model_regs[ra]);
    end
    tests_run++;
    if (reg_b !== model_regs[rb]) begin
      tests_failed++;
      $display("[TB] FAIL %s reg_b[%0d]: got %h expected %h", tag, rb, reg_b, model_regs[rb]);
    end
  endtask

  task automatic check_alu(input logic [1:0] op, input logic [5:0] f,
                           input logic [31:0] a, input logic [31:0] b, input string tag);
    string       name;
    logic [31:0] exp_res;
    alu_op = op;
    funct  = f;
    alu_a  = a;
    alu_b  = b;
    #1;
    name    = ref_op_name(op, f);
    exp_res = ref_result(name, a, b);
    tests_run++;
    if (alu_ctrl !== ref_ctrl(name) || alu_result !== exp_res || zero !== (exp_res == 32'd0)) begin
      tests_failed++;
      $display("[TB] FAIL %s op=%b funct=%h a=%h b=%h: got ctrl=%b res=%h zero=%b expected ctrl=%b res=%h zero=%b",
               tag, op, f, a, b, alu_ctrl, alu_result, zero, ref_ctrl(name), exp_res, exp_res == 32'd0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    #12;
    for (int i = 0; i < 32; i++) check_reads(5'(i), 5'(31 - i), "reset_in");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) check_reads(5'(i), 5'(i), "reset_out");
    do_write(5'd0, 32'hFFFF_FFFF);
    check_reads(5'd0, 5'd0, "r0_hardwired");
  endtask

  task automatic test_regfile();
    do_write(5'd5, 32'h1234_5678);
    do_write(5'd6, 32'h0000_0008);
    check_reads(5'd5, 5'd6, "r5_r6");
    tests_run++;
    if (reg_a !== 32'h1234_5678 || reg_b !== 32'h0000_0008) begin
      tests_failed++;
      $display("[TB] FAIL r5_r6_const: got %h/%h expected 12345678/00000008", reg_a, reg_b);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp;
    @(negedge clk);
    read_reg_a = 5'd5;
    read_reg_b = 5'd6;
    write_reg  = 5'd5;
    write_data = 32'h0000_AAAA;
    reg_write  = 1'b1;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp = 32'h0000_AAAA;
`else
    exp = 32'h1234_5678;
`endif
    tests_run++;
    if (reg_a !== exp || reg_b !== 32'h0000_0008) begin
      tests_failed++;
      $display("[TB] FAIL same_cycle: got %h/%h expected %h/00000008", reg_a, reg_b, exp);
    end
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    model_regs[5] = 32'h0000_AAAA;
    check_reads(5'd5, 5'd6, "after_write");
  endtask

  task automatic test_alu_sweep();
    logic [5:0]  fs   [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [31:0] exps [5] = '{32'hFFFF_001E, 32'hE1E1_0000, 32'h0000_000F, 32'hFFFF_000F, 32'h1};
    for (int i = 0; i < 5; i++) begin
      check_alu(2'b10, fs[i], 32'hF0F0_000F, 32'h0F0F_000F, "sweep");
      tests_run++;
      if (alu_result !== exps[i]) begin
        tests_failed++;
        $display("[TB] FAIL sweep_const funct=%h: got %h expected %h", fs[i], alu_result, exps[i]);
      end
    end
    check_alu(2'b01, 6'h00, 32'h7, 32'h7, "beq_sub");
    check_alu(2'b00, 6'h2A, 32'hFFFF_FFFC, 32'h4, "add_wrap");
    tests_run++;
    if (alu_result !== 32'd0 || zero !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL add_wrap_const: got %h zero=%b expected 00000000 zero=1", alu_result, zero);
    end
    check_alu(2'b10, 6'h2A, 32'h8000_0000, 32'h1, "slt_neg");
    check_alu(2'b10, 6'h2A, 32'h1, 32'h8000_0000, "slt_pos");
    check_alu(2'b10, 6'h3F, 32'h10, 32'h22, "unknown_funct");
    check_alu(2'b11, 6'h22, 32'h10, 32'h22, "aluop_11");
  endtask

  task automatic test_random();
    logic [5:0] fs [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [5:0] f;
    logic [31:0] a;
    for (int i = 0; i < 120; i++) begin
      do_write(5'($urandom_range(0, 31)), $urandom);
      check_reads(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), "rand_rf");
    end
    for (int i = 0; i < 200; i++) begin
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fs[$urandom_range(0, 4)];
      a = $urandom;
      check_alu(2'($urandom_range(0, 3)), f, a, ($urandom_range(0, 7) == 0) ? a : $urandom, "rand_alu");
    end
  endtask

  task automatic test_async_reset();
    do_write(5'd7, 32'hCAFE_F00D);
    do_write(5'd31, 32'h0BAD_BEEF);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    #1;
    for (int i = 0; i < 32; i++) check_reads(5'(i), 5'(i ^ 5'h1F), "async_reset");
    write_reg  = 5'd7;
    write_data = 32'h5555_5555;
    reg_write  = 1'b1;
    read_reg_a = 5'd7;
    @(posedge clk);
    #1;
    check_reads(5'd7, 5'd7, "write_in_reset");
    reg_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reads(5'd7, 5'd31, "after_reset");
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n      = 1'b0;
    reg_write  = 1'b0;
    read_reg_a = '0;
    read_reg_b = '0;
    write_reg  = '0;
    write_data = '0;
    alu_op     = '0;
    funct      = '0;
    alu_a      = '0;
    alu_b      = '0;
    test_reset();
    test_regfile();
    test_same_cycle();
    test_alu_sweep();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
